cursor_grid_ctrl: RTL and testbench

CURSOR_GRID_CTRL -- requirements
Module: cursor_grid_ctrl

---
 rtl/cursor_grid_ctrl.sv | 144 ++++++++++++++
 tb/tb_cursor_grid_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/cursor_grid_ctrl.sv
// Grid cursor controller: synchronized active-low buttons, hold-to-repeat
// stepping with saturate/wrap edges, and a fire strobe with coordinate capture.
module cursor_grid_ctrl #(
  parameter int GRID_W        = 4,
  parameter int GRID_H        = 3,
  parameter int CW            = 4,
  parameter int HOLD_CYCLES   = 50000000,
  parameter int REPEAT_CYCLES = 12500000,
  parameter int WRAP          = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          player_x_up,
  input  logic          player_x_down,
  input  logic          player_y_up,
  input  logic          player_y_down,
  input  logic          player_fire,
  output logic [CW-1:0] player_cursor_x_reg,
  output logic [CW-1:0] player_cursor_y_reg,
  output logic          fire_pulse,
  output logic [CW-1:0] fire_x,
  output logic [CW-1:0] fire_y,
  output logic          moved
);

  localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                        HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNTW = $clog2(MAXC + 1);

  localparam logic [CNTW-1:0] HOLD_LAST = CNTW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] REP_LAST  = CNTW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0]   X_MAX     = CW'(GRID_W - 1);
  localparam logic [CW-1:0]   Y_MAX     = CW'(GRID_H - 1);

  typedef enum logic [1:0] {IDLE, STEP, DELAY, REPEAT} state_t;

  state_t          state;
  logic [CNTW-1:0] cnt;
  logic            first_step;
  logic [4:0]      s1, s2;
  logic            fire_prev;

  logic [4:0] raw;
  logic [4:0] pr;
  logic       x_inc, x_dec, y_inc, y_dec;
  logic       any_req;
  logic       fire_edge;
  logic [CW-1:0] x_nxt, y_nxt;

  assign raw = {player_x_up, player_x_down, player_y_up,
                player_y_down, player_fire};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '1;
      s2 <= '1;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Opposing buttons on one axis cancel each other out.
  assign pr        = ~s2;
  assign x_inc     = pr[4] & ~pr[3];
  assign x_dec     = pr[3] & ~pr[4];
  assign y_inc     = pr[2] & ~pr[1];
  assign y_dec     = pr[1] & ~pr[2];
  assign any_req   = x_inc | x_dec | y_inc | y_dec;
  assign fire_edge = fire_prev & ~s2[0];

  function automatic logic [CW-1:0] step_coord(
    input logic [CW-1:0] c,
    input logic          inc,
    input logic          dec,
    input logic [CW-1:0] cmax
  );
    logic [CW-1:0] r;
    r = c;
    if (inc) begin
      if (c == cmax) r = (WRAP != 0) ? '0 : c;
      else           r = c + CW'(1);
    end else if (dec) begin
      if (c == '0)   r = (WRAP != 0) ? cmax : c;
      else           r = c - CW'(1);
    end
    return r;
  endfunction

  assign x_nxt = step_coord(player_cursor_x_reg, x_inc, x_dec, X_MAX);
  assign y_nxt = step_coord(player_cursor_y_reg, y_inc, y_dec, Y_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      first_step          <= 1'b0;
      player_cursor_x_reg <= '0;
      player_cursor_y_reg <= '0;
      moved               <= 1'b0;
      fire_prev           <= 1'b1;
      fire_pulse          <= 1'b0;
      fire_x              <= '0;
      fire_y              <= '0;
    end else begin
      moved      <= 1'b0;
      fire_prev  <= s2[0];
      fire_pulse <= fire_edge;
      if (fire_edge) begin
        fire_x <= player_cursor_x_reg;
        fire_y <= player_cursor_y_reg;
      end
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state      <= STEP;
            first_step <= 1'b1;
          end
        end
        STEP: begin
          player_cursor_x_reg <= x_nxt;
          player_cursor_y_reg <= y_nxt;
          moved      <= (x_nxt != player_cursor_x_reg) ||
                        (y_nxt != player_cursor_y_reg);
          cnt        <= '0;
          first_step <= 1'b0;
          state      <= first_step ? DELAY : REPEAT;
        end
        DELAY: begin
          if (!any_req)              state <= IDLE;
          else if (cnt == HOLD_LAST) state <= STEP;
          else                       cnt   <= cnt + CNTW'(1);
        end
        REPEAT: begin
          if (!any_req)             state <= IDLE;
          else if (cnt == REP_LAST) state <= STEP;
          else                      cnt   <= cnt + CNTW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cursor_grid_ctrl.sv
// Bench for cursor_grid_ctrl: saturating and wrapping instances side by side,
// directed table, corner sequences and random holds against a timestamp model.
module tb_cursor_grid_ctrl;

  localparam int GW = 4;
  localparam int GH = 3;
  localparam int H  = 8;
  localparam int R  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] press = 5'b0;

  logic [3:0] cx [2];
  logic [3:0] cy [2];
  logic [3:0] fx [2];
  logic [3:0] fy [2];
  logic       fp [2];
  logic       mv [2];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cursor_grid_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .CW(4),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .WRAP(0)
  ) u0 (
    .clk(clk), .rst(rst),
    .player_x_up(~press[4]), .player_x_down(~press[3]),
    .player_y_up(~press[2]), .player_y_down(~press[1]),
    .player_fire(~press[0]),
    .player_cursor_x_reg(cx[0]), .player_cursor_y_reg(cy[0]),
    .fire_pulse(fp[0]), .fire_x(fx[0]), .fire_y(fy[0]),
    .moved(mv[0])
  );

  cursor_grid_ctrl #(
    .GRID_W(GW), .GRID_H(GH), .CW(4),
    .HOLD_CYCLES(H), .REPEAT_CYCLES(R), .WRAP(1)
  ) u1 (
    .clk(clk), .rst(rst),
    .player_x_up(~press[4]), .player_x_down(~press[3]),
    .player_y_up(~press[2]), .player_y_down(~press[1]),
    .player_fire(~press[0]),
    .player_cursor_x_reg(cx[1]), .player_cursor_y_reg(cy[1]),
    .fire_pulse(fp[1]), .fire_x(fx[1]), .fire_y(fy[1]),
    .moved(mv[1])
  );

  // Model: press masks (1 = pressed) delayed two edges, steps scheduled
  // by edge timestamps: start+1, then +HOLD+1, then +REPEAT+1.
  logic [4:0] m_s1, m_s2;
  bit         m_fprev;
  int         n;
  int         m_x [2], m_y [2], m_fx [2], m_fy [2], m_at [2];
  bit         m_act [2], m_first [2], m_mv [2], m_fp [2];

  function automatic int mvc(int c, int d, int g, int w);
    int t;
    t = c + d;
    if (t < 0)  return (w != 0) ? g - 1 : 0;
    if (t >= g) return (w != 0) ? 0 : g - 1;
    return t;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_fprev = 1'b0;
    for (int w = 0; w < 2; w++) begin
      m_x[w] = 0; m_y[w] = 0; m_fx[w] = 0; m_fy[w] = 0; m_at[w] = 0;
      m_act[w] = 0; m_first[w] = 0; m_mv[w] = 0; m_fp[w] = 0;
    end
  endtask

  task automatic model_edge();
    int dx, dy, nx, ny;
    bit fe, anyr;
    dx = (m_s2[4] && !m_s2[3]) ? 1 : (m_s2[3] && !m_s2[4]) ? -1 : 0;
    dy = (m_s2[2] && !m_s2[1]) ? 1 : (m_s2[1] && !m_s2[2]) ? -1 : 0;
    anyr = (dx != 0) || (dy != 0);
    fe = !m_fprev && m_s2[0];
    for (int w = 0; w < 2; w++) begin
      m_mv[w] = 0;
      m_fp[w] = fe;
      if (fe) begin
        m_fx[w] = m_x[w];
        m_fy[w] = m_y[w];
      end
      if (!m_act[w]) begin
        if (anyr) begin
          m_act[w] = 1; m_first[w] = 1; m_at[w] = n + 1;
        end
      end else if (n == m_at[w]) begin
        nx = mvc(m_x[w], dx, GW, w);
        ny = mvc(m_y[w], dy, GH, w);
        m_mv[w] = (nx != m_x[w]) || (ny != m_y[w]);
        m_x[w] = nx; m_y[w] = ny;
        m_at[w] = n + 1 + (m_first[w] ? H : R);
        m_first[w] = 0;
      end else if (!anyr) begin
        m_act[w] = 0;
      end
    end
    m_fprev = m_s2[0];
    m_s2 = m_s1;
    m_s1 = press;
    n++;
  endtask

  task automatic model_check();
    for (int w = 0; w < 2; w++) begin
      check($sformatf("x%0d", w),  int'(cx[w]), m_x[w]);
      check($sformatf("y%0d", w),  int'(cy[w]), m_y[w]);
      check($sformatf("mv%0d", w), int'(mv[w]), int'(m_mv[w]));
      check($sformatf("fp%0d", w), int'(fp[w]), int'(m_fp[w]));
      check($sformatf("fx%0d", w), int'(fx[w]), m_fx[w]);
      check($sformatf("fy%0d", w), int'(fy[w]), m_fy[w]);
    end
  endtask

  task automatic tick(input logic [4:0] p);
    press = p;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    model_check();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int w = 0; w < 2; w++) begin
      check($sformatf("rst_x%0d", w),  int'(cx[w]), 0);
      check($sformatf("rst_y%0d", w),  int'(cy[w]), 0);
      check($sformatf("rst_mv%0d", w), int'(mv[w]), 0);
      check($sformatf("rst_fp%0d", w), int'(fp[w]), 0);
      check($sformatf("rst_fx%0d", w), int'(fx[w]), 0);
      check($sformatf("rst_fy%0d", w), int'(fy[w]), 0);
    end
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [4:0] p;
    int len;
    int x0, y0, x1, y1;
  } vec_t;

  vec_t tbl [12];

  initial begin
    // press bits: x_up, x_down, y_up, y_down, fire
    tbl[0]  = '{5'b00000,  4, 0, 0, 0, 0};
    tbl[1]  = '{5'b10000,  3, 0, 0, 0, 0};
    tbl[2]  = '{5'b00000, 10, 1, 0, 1, 0};
    tbl[3]  = '{5'b10000, 40, 3, 0, 0, 0};
    tbl[4]  = '{5'b00000, 12, 3, 0, 0, 0};
    tbl[5]  = '{5'b00010, 15, 3, 0, 0, 1};
    tbl[6]  = '{5'b00000, 10, 3, 0, 0, 1};
    tbl[7]  = '{5'b11000, 20, 3, 0, 0, 1};
    tbl[8]  = '{5'b10100,  3, 3, 0, 0, 1};
    tbl[9]  = '{5'b00000, 10, 3, 1, 1, 2};
    tbl[10] = '{5'b00001, 20, 3, 1, 1, 2};
    tbl[11] = '{5'b00000,  4, 3, 1, 1, 2};

    n = 0;
    do_reset();

    for (int i = 0; i < 12; i++) begin
      repeat (tbl[i].len) tick(tbl[i].p);
      check($sformatf("tbl%0d_x0", i), int'(cx[0]), tbl[i].x0);
      check($sformatf("tbl%0d_y0", i), int'(cy[0]), tbl[i].y0);
      check($sformatf("tbl%0d_x1", i), int'(cx[1]), tbl[i].x1);
      check($sformatf("tbl%0d_y1", i), int'(cy[1]), tbl[i].y1);
    end

    // Fire edge lands on the same edge as a step: pre-step capture.
    tick(5'b01000);
    repeat (3) tick(5'b01001);
    check("coinc_fp0", int'(fp[0]), 1);
    check("coinc_fx0", int'(fx[0]), 3);
    check("coinc_x0",  int'(cx[0]), 2);
    check("coinc_fx1", int'(fx[1]), 1);
    check("coinc_x1",  int'(cx[1]), 0);
    repeat (6) tick(5'b01001);
    repeat (15) tick(5'b00000);

    // Reset in REPEAT with x_up held across it.
    do_reset();
    repeat (25) tick(5'b10000);
    #2;
    do_reset();
    repeat (3) tick(5'b10000);
    check("rst_hold_x0_pre", int'(cx[0]), 0);
    check("rst_hold_mv0_pre", int'(mv[0]), 0);
    tick(5'b10000);
    check("rst_hold_x0", int'(cx[0]), 1);
    check("rst_hold_mv0", int'(mv[0]), 1);
    repeat (15) tick(5'b10000);
    repeat (10) tick(5'b00000);

    for (int s = 0; s < 300; s++) begin
      logic [4:0] p;
      int len;
      p = 5'($urandom_range(0, 31));
      len = $urandom_range(1, 14);
      repeat (len) tick(p);
      if ($urandom_range(0, 60) == 0) begin
        #2;
        do_reset();
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
